// File: rtl/alu_iter.sv
// Handshaked RV32I/RV32IM execution unit: base ops settle in one cycle, M-extension ops iterate XLEN cycles.
// Define ALU_MULDIV_EN to compile in the iterative multiply/divide datapath and BUSY state.
module alu_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    function automatic logic [XLEN-1:0] base_op(input logic [4:0] op,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $unsigned($signed(x) >>> sh);
            OP_SLT:  r = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, x < y};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_MULDIV_EN
    localparam logic [1:0] S_BUSY = 2'd1;

    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   dv_q, dv_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic              is_iter;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN-1:0]   setup_lo, setup_dv;
    logic              setup_neg;

    assign is_iter = (alu_ctrl >= OP_MUL) && (alu_ctrl <= OP_REMU);
    assign a_abs   = a[XLEN-1] ? -a : a;
    assign b_abs   = b[XLEN-1] ? -b : b;

    always_comb begin
        setup_lo  = a;
        setup_dv  = b;
        setup_neg = 1'b0;
        case (alu_ctrl)
            OP_MULH, OP_DIV: begin
                setup_lo  = a_abs;
                setup_dv  = b_abs;
                setup_neg = a[XLEN-1] ^ b[XLEN-1];
            end
            OP_MULHSU: begin
                setup_lo  = a_abs;
                setup_neg = a[XLEN-1];
            end
            OP_REM: begin
                setup_lo  = a_abs;
                setup_dv  = b_abs;
                setup_neg = a[XLEN-1];
            end
            default: ;
        endcase
    end

    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   quo, rem, iter_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dv_q} : '0);
        div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_rem - {1'b0, dv_q};
        if (op_q <= OP_MULHU)
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_step = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod = neg_q ? -acc_step : acc_step;
        quo  = acc_step[XLEN-1:0];
        rem  = acc_step[2*XLEN-1:XLEN];
    end

    // Divide-by-zero and signed overflow are resolved here, after the full iteration count.
    always_comb begin
        case (op_q)
            OP_MUL:                      iter_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: iter_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:
                iter_res = (dv_q == '0) ? '1 : ovf_q ? a_q : (neg_q ? -quo : quo);
            OP_REM, OP_REMU:
                iter_res = (dv_q == '0) ? a_q : ovf_q ? '0 : (neg_q ? -rem : rem);
            default:                     iter_res = '0;
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_MULDIV_EN
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        dv_d  = dv_q;
        acc_d = acc_q;
        neg_d = neg_q;
        ovf_d = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (is_iter) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        op_d    = alu_ctrl;
                        a_d     = a;
                        dv_d    = setup_dv;
                        acc_d   = {{XLEN{1'b0}}, setup_lo};
                        neg_d   = setup_neg;
                        ovf_d   = ((alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM)) &&
                                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
                    end else
`endif
                    begin
                        result_d = base_op(alu_ctrl, a, b);
                        zero_d   = (result_d == '0);
                        state_d  = S_DONE;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(XLEN-1)) begin
                    result_d = iter_res;
                    zero_d   = (iter_res == '0);
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            dv_q  <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_MULDIV_EN
            cnt_q <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            dv_q  <= dv_d;
            acc_q <= acc_d;
            neg_q <= neg_d;
            ovf_q <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
`ifdef ALU_MULDIV_EN
    assign busy = (state_q == S_BUSY);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, multi-cycle corner sequences, random vs. reference model.
module tb_alu_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a, b;
    logic [4:0]      alu_ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit is_iter(input logic [4:0] op);
`ifdef ALU_MULDIV_EN
        return (op >= 5'd10) && (op <= 5'd17);
`else
        return (op == 5'd31) && (op != 5'd31);
`endif
    endfunction

    // Reference model built from 64-bit host arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy;
        logic [63:0] p, ux64, uy64;
        bit          ovf;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        uy   = longint'({32'b0, y});
        ux64 = {32'b0, x};
        uy64 = {32'b0, y};
        ovf  = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            5'd0: return x + y;
            5'd1: return x - y;
            5'd2: return x & y;
            5'd3: return x | y;
            5'd4: return x ^ y;
            5'd5: return x << y[4:0];
            5'd6: return x >> y[4:0];
            5'd7: return $unsigned($signed(x) >>> y[4:0]);
            5'd8: return {31'b0, $signed(x) < $signed(y)};
            5'd9: return {31'b0, x < y};
`ifdef ALU_MULDIV_EN
            5'd10: begin p = ux64 * uy64; return p[31:0]; end
            5'd11: begin p = sx * sy; return p[63:32]; end
            5'd12: begin p = sx * uy; return p[63:32]; end
            5'd13: begin p = ux64 * uy64; return p[63:32]; end
            5'd14: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                p = sx / sy; return p[31:0];
            end
            5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd16: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            5'd17: return (y == 0) ? x : x % y;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Presents one op, waits for out_valid (bounded), returns result, zero, latency and busy-cycle count.
    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic z, output int lat, output int bcnt);
        in_valid = 1'b1; alu_ctrl = op; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_ctrl = 5'($urandom);
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero;
        @(posedge clk); #1;
    endtask

    task automatic apply(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string name);
        logic [31:0] r;
        logic        z;
        int          lat, bcnt, exp_lat;
        exp_lat = is_iter(op) ? XLEN + 1 : 1;
        run_op(op, x, y, r, z, lat, bcnt);
        chk({name, " result"}, r, exp);
        chk({name, " zero"}, {31'b0, z}, {31'b0, exp == 32'h0});
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " busy cycles"}, bcnt, exp_lat - 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  rop;
        logic [31:0] rx, ry;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_ctrl = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset result", result, 32'h0);
        chk("reset zero", {31'b0, zero}, 32'd0);

        tbl.push_back('{5'd0,  32'd5,         32'd7,         32'd12,        "ADD 5+7"});
        tbl.push_back('{5'd1,  32'd7,         32'd7,         32'd0,         "SUB 7-7"});
        tbl.push_back('{5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, "SRA"});
        tbl.push_back('{5'd6,  32'h8000_0000, 32'h24,        32'h0800_0000, "SRL"});
        tbl.push_back('{5'd9,  32'd1,         32'hFFFF_FFFF, 32'd1,         "SLTU"});
        tbl.push_back('{5'd8,  32'd1,         32'hFFFF_FFFF, 32'd0,         "SLT"});
        tbl.push_back('{5'd5,  32'd1,         32'd31,        32'h8000_0000, "SLL 31"});
        tbl.push_back('{5'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "AND"});
        tbl.push_back('{5'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "OR"});
        tbl.push_back('{5'd4,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, "XOR"});
        tbl.push_back('{5'd20, 32'd9,         32'd3,         32'd0,         "op 20"});
`ifdef ALU_MULDIV_EN
        tbl.push_back('{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         "MULH -1*-1"});
        tbl.push_back('{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU"});
        tbl.push_back('{5'd10, 32'd6,         32'd7,         32'd42,        "MUL 6*7"});
        tbl.push_back('{5'd12, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "MULHSU -1*2"});
        tbl.push_back('{5'd14, 32'd7,         32'd0,         32'hFFFF_FFFF, "DIV 7/0"});
        tbl.push_back('{5'd17, 32'd7,         32'd0,         32'd7,         "REMU 7/0"});
        tbl.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"});
        tbl.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "REM ovf"});
        tbl.push_back('{5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV -7/2"});
        tbl.push_back('{5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM -7/2"});
`else
        tbl.push_back('{5'd10, 32'd6,         32'd7,         32'd0,         "MUL disabled"});
        tbl.push_back('{5'd14, 32'd7,         32'd0,         32'd0,         "DIV disabled"});
`endif
        foreach (tbl[i]) apply(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].exp, tbl[i].name);

        // Backpressure: DONE must hold while out_ready is low, ignoring in_valid.
        out_ready = 1'b0;
        in_valid = 1'b1; alu_ctrl = 5'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); alu_ctrl = 5'd1; a = 32'd9; b = 32'd9;
            @(posedge clk); #1;
            chk("hold result", result, 32'd7);
            chk("hold out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release in_ready", {31'b0, in_ready}, 32'd1);
        chk("release out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("no stray accept", {31'b0, out_valid}, 32'd0);
        chk("result held in idle", result, 32'd7);

        // Reset in the middle of a DIVU (or in DONE when the M ops are single-cycle).
        out_ready = 1'b0;
        in_valid = 1'b1; alu_ctrl = 5'd15; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
`ifdef ALU_MULDIV_EN
        chk("busy mid divide", {31'b0, busy}, 32'd1);
`else
        chk("busy mid divide", {31'b0, busy}, 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        chk("abort in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort result", result, 32'h0);
        apply(5'd0, 32'd100, 32'd23, 32'd123, "ADD after abort");

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop = 5'($urandom_range(0, 31));
            rx  = pick();
            ry  = pick();
            apply(rop, rx, ry, ref_alu(rop, rx, ry), $sformatf("rand op%0d %h,%h", rop, rx, ry));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
